// File: rtl/case_2.sv
// T-junction traffic signal controller: Moore FSM stepped by a 1 Hz tick.
// The side road is served only when a vehicle is waiting as main road 1 finishes its turn phase.
module case_2 #(
    parameter int T_S1 = 7,
    parameter int T_S2 = 2,
    parameter int T_S3 = 5,
    parameter int T_S4 = 2,
    parameter int T_S5 = 3,
    parameter int T_S6 = 2
) (
    output logic [2:0] main_road1,
    output logic [2:0] main_road1T,
    output logic [2:0] main_road2,
    output logic [2:0] side_road,
    input  logic       SENSOR,
    input  logic       clk,
    output logic [7:0] count,
    input  logic       rst_n
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Terminal count of each state: the state ends on the edge where count equals this.
    localparam logic [7:0] LAST_S1 = 8'(T_S1 - 1);
    localparam logic [7:0] LAST_S2 = 8'(T_S2 - 1);
    localparam logic [7:0] LAST_S3 = 8'(T_S3 - 1);
    localparam logic [7:0] LAST_S4 = 8'(T_S4 - 1);
    localparam logic [7:0] LAST_S5 = 8'(T_S5 - 1);
    localparam logic [7:0] LAST_S6 = 8'(T_S6 - 1);

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] last;
    state_t     state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S1;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        last      = 8'd0;
        state_nxt = S1;
        state_d   = S1;
        count_d   = 8'd0;
        case (state_q)
            S1: begin last = LAST_S1; state_nxt = S2; end
            S2: begin last = LAST_S2; state_nxt = S3; end
            S3: begin last = LAST_S3; state_nxt = S4; end
            S4: begin last = LAST_S4; state_nxt = SENSOR ? S5 : S1; end
            S5: begin last = LAST_S5; state_nxt = S6; end
            S6: begin last = LAST_S6; state_nxt = S1; end
            default: begin last = 8'd0; state_nxt = S1; end
        endcase
        // An illegal encoding has last=0, so it falls straight back to S1 with count cleared.
        if (count_q >= last) begin
            state_d = state_nxt;
            count_d = 8'd0;
        end else begin
            state_d = state_q;
            count_d = count_q + 8'd1;
        end
    end

    always_comb begin
        main_road1  = RED;
        main_road1T = RED;
        main_road2  = RED;
        side_road   = RED;
        case (state_q)
            S1: begin main_road1 = GREEN;  main_road2  = GREEN;  end
            S2: begin main_road1 = GREEN;  main_road2  = YELLOW; end
            S3: begin main_road1 = GREEN;  main_road1T = GREEN;  end
            S4: begin main_road1 = YELLOW; main_road1T = YELLOW; end
            S5: side_road = GREEN;
            S6: side_road = YELLOW;
            default: ;
        endcase
    end

    assign count = count_q;

endmodule

// File: tb/tb_case_2.sv
// Bench for case_2: scripted phase tables for the corner sequences, then a long
// randomized run against a phase-schedule reference model.
module tb_case_2;

    logic [2:0] main_road1, main_road1T, main_road2, side_road;
    logic       SENSOR;
    logic       clk;
    logic [7:0] count;
    logic       rst_n;

    case_2 dut (
        .main_road1 (main_road1),
        .main_road1T(main_road1T),
        .main_road2 (main_road2),
        .side_road  (side_road),
        .SENSOR     (SENSOR),
        .clk        (clk),
        .count      (count),
        .rst_n      (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Lamps packed as {M1, M1T, M2, SIDE}.
    localparam logic [11:0] L1 = {G, R, G, R};
    localparam logic [11:0] L2 = {G, R, Y, R};
    localparam logic [11:0] L3 = {G, G, R, R};
    localparam logic [11:0] L4 = {Y, Y, R, R};
    localparam logic [11:0] L5 = {R, R, R, G};
    localparam logic [11:0] L6 = {R, R, R, Y};

    typedef struct {
        logic        sensor;
        logic [11:0] lamps;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic [11:0] ph_lamp [6];
    int          ph_dur  [6];
    int          m_ph, m_t;

    // Each entry is the state expected after one clock edge, with SENSOR held at .sensor before it.
    function automatic void add(logic s, logic [11:0] l, int from, int to);
        for (int c = from; c <= to; c++) begin
            vec_t v;
            v.sensor = s;
            v.lamps  = l;
            v.cnt    = 8'(c);
            tbl.push_back(v);
        end
    endfunction

    task automatic chk(string name, logic [19:0] act, logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_true(string name, logic cond);
        checks++;
        if (cond !== 1'b1) begin
            errors++;
            $display("FAIL %s actual=0 expected=1 lamps=%b_%b_%b_%b count=%0d @%0t",
                     name, main_road1, main_road1T, main_road2, side_road, count, $time);
        end
    endtask

    function automatic logic onehot3(logic [2:0] l);
        return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
    endfunction

    function automatic logic [19:0] dut_out();
        return {main_road1, main_road1T, main_road2, side_road, count};
    endfunction

    // Reference: walk the phase schedule; sensor only matters when leaving the turn-yellow phase.
    function automatic void model_step(logic s);
        if (m_t < ph_dur[m_ph] - 1) m_t++;
        else begin
            m_t = 0;
            case (m_ph)
                3:       m_ph = s ? 4 : 0;
                5:       m_ph = 0;
                default: m_ph = m_ph + 1;
            endcase
        end
    endfunction

    initial begin
        ph_lamp = '{L1, L2, L3, L4, L5, L6};
        ph_dur  = '{7, 2, 5, 2, 3, 2};

        // Round 1: no vehicle, 16-cycle loop.
        add(0, L1, 1, 6); add(0, L2, 0, 1); add(0, L3, 0, 4); add(0, L4, 0, 1); add(0, L1, 0, 0);
        // Round 2: sensor pulses in S1..S3 but is low at the final S4 edge.
        add(1, L1, 1, 6); add(1, L2, 0, 1); add(1, L3, 0, 4); add(0, L4, 0, 1); add(0, L1, 0, 0);
        // Round 3: sensor high on the final S4 edge, dropped during S5; 21-cycle loop.
        add(0, L1, 1, 6); add(0, L2, 0, 1); add(0, L3, 0, 4); add(0, L4, 0, 0); add(0, L4, 1, 1);
        add(1, L5, 0, 0); add(0, L5, 1, 2); add(0, L6, 0, 1); add(0, L1, 0, 0);

        SENSOR = 1'b0;
        rst_n  = 1'b0;
        #2;
        chk("reset_async", dut_out(), {L1, 8'd0});
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", dut_out(), {L1, 8'd0});
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            SENSOR = tbl[k].sensor;
            @(posedge clk);
            #1;
            chk($sformatf("tbl[%0d]", k), dut_out(), {tbl[k].lamps, tbl[k].cnt});
        end

        // Asynchronous reset in the middle of S3.
        SENSOR = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_s3", dut_out(), {L3, 8'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_s3_reset", dut_out(), {L1, 8'd0});
        @(posedge clk);
        #1;
        chk("mid_s3_reset_hold", dut_out(), {L1, 8'd0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_count", dut_out(), {L1, 8'd1});

        // Long randomized run: sensor toggles every 40 s with occasional random flips.
        m_ph = 0;
        m_t  = 1;
        for (int i = 0; i < 2000; i++) begin
            SENSOR = (((i / 40) % 2) == 1) ^ ($urandom_range(0, 9) == 0);
            @(posedge clk);
            model_step(SENSOR);
            #1;
            chk("rand_model", dut_out(), {ph_lamp[m_ph], 8'(m_t)});
            chk_true("onehot", onehot3(main_road1) && onehot3(main_road1T) &&
                               onehot3(main_road2) && onehot3(side_road));
            chk_true("no_conflict", side_road != G ||
                     (main_road1 == R && main_road1T == R && main_road2 == R));
            chk_true("count_bound", int'(count) < ph_dur[m_ph]);
            if (i == 1000) begin
                #2 rst_n = 1'b0;
                m_ph = 0;
                m_t  = 0;
                #1;
                chk("rand_reset", dut_out(), {L1, 8'd0});
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
